// File: rtl/pipe_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mem_responder
// Description : Memory responder for a ready/valid pipeline port. Writes
//               complete in place; reads return in order after LATENCY
//               cycles through a credit-protected response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mem_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_op,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_data,
  output logic [$clog2(RESP_DEPTH):0]   outstanding
);

  localparam int                c_ptr_w = $clog2(RESP_DEPTH);
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(RESP_DEPTH);

  logic [31:0]          r_mem     [1 << ADDR_BITS];
  logic [31:0]          r_dl_data [LATENCY];
  logic [LATENCY-1:0]   r_dl_valid;
  logic [31:0]          r_fifo    [RESP_DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_ptr_w:0]     r_count;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_acc;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_unused_addr_bits;

  assign w_idx              = req_addr[ADDR_BITS+1:2];
  assign w_unused_addr_bits = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};

  // Credit check uses registered state only, so ready never depends on valid.
  assign req_ready  = (outstanding < c_depth);
  assign w_acc      = req_valid & req_ready;
  assign w_rd_acc   = w_acc & ~req_op;
  assign w_wr_acc   = w_acc &  req_op;

  assign w_push     = r_dl_valid[LATENCY-1];
  assign resp_valid = (r_count != '0);
  assign resp_data  = r_fifo[r_rptr];
  assign w_pop      = resp_valid & resp_ready;

  // Array and delay-line payload are never reset; only validity is.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_idx] <= req_wdata;
    end
    r_dl_data[0] <= r_mem[w_idx];
    for (int i = 1; i < LATENCY; i++) begin
      r_dl_data[i] <= r_dl_data[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_valid  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      outstanding <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_dl_valid[0] <= w_rd_acc;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
      end

      if (w_push) begin
        r_fifo[r_wptr] <= r_dl_data[LATENCY-1];
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case ({w_rd_acc, w_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mem_responder
// Description : Directed self-checking bench: vector table plus multi-cycle
//               sequences for back-pressure, full FIFO and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_responder;

  localparam int ADDR_BITS  = 10;
  localparam int LATENCY    = 2;
  localparam int RESP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [$clog2(RESP_DEPTH):0] outstanding;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_mem_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .LATENCY    (LATENCY),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .outstanding (outstanding)
  );

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic op, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Single read with resp_ready held high; checks exact response timing.
  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    resp_ready = 1'b1;
    do_req(1'b0, addr, '0);
    chk({name, " out=1"}, 32'(outstanding), 32'd1);
    chk({name, " early"}, 32'(resp_valid), 32'd0);
    repeat (LATENCY - 1) tick();
    chk({name, " early2"}, 32'(resp_valid), 32'd0);
    tick();
    chk({name, " valid"}, 32'(resp_valid), 32'd1);
    chk({name, " data"}, resp_data, exp);
    tick();
    chk({name, " popped"}, 32'(resp_valid), 32'd0);
    chk({name, " out=0"}, 32'(outstanding), 32'd0);
  endtask

  task automatic fill_four();
    resp_ready = 1'b0;
    do_req(1'b0, 32'h0, '0);
    do_req(1'b0, 32'h4, '0);
    do_req(1'b0, 32'h8, '0);
    do_req(1'b0, 32'hC, '0);
  endtask

  initial begin
    int stale;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_1004, 32'h5,         32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h5};
    vecs[4]  = '{1'b0, 32'hFFFF_F007, 32'h0,         32'h5};
    vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_5A5A};
    vecs[7]  = '{1'b1, 32'h0000_0000, 32'h1,         32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0004, 32'h2,         32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0008, 32'h3,         32'h0};
    vecs[10] = '{1'b1, 32'h0000_000C, 32'h4,         32'h0};
    vecs[11] = '{1'b1, 32'h0000_0020, 32'h7,         32'h0};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) tick();
    chk("rst req_ready",   32'(req_ready),   32'd1);
    chk("rst resp_valid",  32'(resp_valid),  32'd0);
    chk("rst resp_data",   resp_data,        32'd0);
    chk("rst outstanding", 32'(outstanding), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].op) begin
        chk($sformatf("vec%0d wr ready", i), 32'(req_ready), 32'd1);
        do_req(1'b1, vecs[i].addr, vecs[i].wdata);
        chk($sformatf("vec%0d wr no count", i), 32'(outstanding), 32'd0);
      end else begin
        read_check($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].exp);
      end
    end

    // Back-pressure: four reads queue up, then drain in order.
    fill_four();
    chk("bp ready low", 32'(req_ready),   32'd0);
    chk("bp out=4",     32'(outstanding), 32'd4);
    repeat (LATENCY + 1) tick();
    chk("bp valid",     32'(resp_valid),  32'd1);
    chk("bp hold data", resp_data,        32'd1);
    resp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("bp pop%0d", k), resp_data, 32'(k));
      tick();
    end
    chk("bp empty",     32'(resp_valid),  32'd0);
    chk("bp ready hi",  32'(req_ready),   32'd1);
    chk("bp out=0",     32'(outstanding), 32'd0);

    // Read in flight must not see a write accepted one cycle later.
    resp_ready = 1'b1;
    do_req(1'b0, 32'h20, '0);
    do_req(1'b1, 32'h20, 32'h9);
    tick();
    chk("rw old valid", 32'(resp_valid), 32'd1);
    chk("rw old data",  resp_data,       32'd7);
    tick();
    read_check("rw new", 32'h20, 32'h9);

    // Full FIFO: pop and request together; the request must wait a cycle.
    fill_four();
    repeat (LATENCY + 1) tick();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = 1'b0;
    req_addr   = 32'h8;
    chk("full ready low", 32'(req_ready), 32'd0);
    tick();
    chk("full out=3",     32'(outstanding), 32'd3);
    chk("full ready hi",  32'(req_ready),   32'd1);
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("full out=4",     32'(outstanding), 32'd4);
    resp_ready = 1'b1;
    chk("full d0", resp_data, 32'd2);
    tick();
    chk("full d1", resp_data, 32'd3);
    tick();
    chk("full d2", resp_data, 32'd4);
    tick();
    chk("full d3", resp_data, 32'd3);
    tick();
    chk("full drained", 32'(resp_valid),  32'd0);
    chk("full out=0",   32'(outstanding), 32'd0);

    // Reset with one response queued and two reads in flight.
    resp_ready = 1'b0;
    do_req(1'b0, 32'h0, '0);
    tick();
    do_req(1'b0, 32'h4, '0);
    do_req(1'b0, 32'h8, '0);
    chk("pre-rst valid", 32'(resp_valid),  32'd1);
    chk("pre-rst out=3", 32'(outstanding), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid-rst valid",  32'(resp_valid),  32'd0);
    chk("mid-rst out=0",  32'(outstanding), 32'd0);
    chk("mid-rst ready",  32'(req_ready),   32'd1);
    repeat (2) tick();
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      tick();
      if (resp_valid) stale++;
    end
    chk("no stale resp", 32'(stale), 32'd0);
    read_check("persist 0x20", 32'h20, 32'h9);
    read_check("persist top",  32'hFFC, 32'hA5A5_5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
